ice40_weight_store_gen: RTL and testbench
=========================================

Name: ice40_weight_store_gen

Overview:
- Parametrised next-generation weight/coefficient store for the SensAI audio and keyword pipelines.
- Sequential write port for weight configuration. Sequential read port with ready/valid output back-pressure, a programmable read base address, and an optional replay (loop) mode.
- Memory is split into NUM_BANKS inferred banks selected by the upper address bits. It sits between the weight loader and the MAC/filter-bank engines.

Parameters:
- DATA_W, 16, weight word width in bits (1..32).
- DEPTH, 16384, total words; power of two, at least NUM_BANKS; AW = log2(DEPTH).
- NUM_BANKS, 1, power of two (1, 2, 4, 8); bank = addr[AW-1 -: log2(NUM_BANKS)].
- LOOP_MODE, 0, 0 = read address wraps at DEPTH-1 to 0; 1 = read address wraps at the last written word back to the latched base.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_init_addr  in  1  clear write pointer and word count.
- i_wgt_wr  in  1  write strobe.
- i_wgt_in  in  DATA_W  write data.
- o_full  out  1  write count == DEPTH.
- o_wr_count  out  AW+1  number of words written since init.
- i_rst_addr  in  1  load read pointer with i_base_addr and flush the read pipeline.
- i_base_addr  in  AW  read start address, sampled on i_rst_addr.
- i_rd  in  1  read request.
- o_rd_ready  out  1  read request will be accepted this cycle.
- o_weight  out  DATA_W  read data.
- o_weight_val  out  1  o_weight valid.
- i_weight_rdy  in  1  consumer accepts o_weight.
- o_parity_err  out  1  sticky parity error.

Behaviour:
- Reset: waddr, o_wr_count, raddr, latched base, pipeline, o_weight, o_weight_val, o_full and o_parity_err all go to 0. o_rd_ready is 0 while reset is high and 1 on the first cycle after.
- Write:
  - Accepted when i_wgt_wr && !o_full.
  - On accept, mem[waddr] <= i_wgt_in, waddr+1, o_wr_count+1.
  - Writes while full are dropped; state is unchanged.
  - i_init_addr has priority: if asserted together with i_wgt_wr, the write is dropped and count/pointer go to 0.
- Read accept: i_rd && o_rd_ready && !i_rst_addr. On accept, a synchronous read of mem[raddr] is issued and raddr advances.
- Read address advance:
  - LOOP_MODE=0: raddr+1, wrapping from DEPTH-1 to 0.
  - LOOP_MODE=1: if raddr+1 == o_wr_count, raddr <= latched base; otherwise raddr+1. With o_wr_count == 0, raddr holds.
- Latency: a read accepted in cycle N presents o_weight/o_weight_val=1 in cycle N+1 when the output is not stalled.
- Back-pressure:
  - A 2-entry skid (output register plus one holding register) absorbs the in-flight read.
  - o_rd_ready = (occupancy + in-flight) < 2.
  - While o_weight_val && !i_weight_rdy, o_weight is held stable.
  - No word is dropped or duplicated; the read order is preserved.
- Bank select: the bank index of the issued read is registered alongside the request so that the output mux matches the data after 1 cycle.
- Same-address write and read in the same cycle: the read returns the old contents (read-before-write).
- i_rst_addr:
  - raddr and latched base <= i_base_addr.
  - The skid and any in-flight read are discarded, so o_weight_val=0 next cycle.
  - A simultaneous i_rd is not accepted.
  - Writes are unaffected.
- Reset mid-burst: the pipeline is discarded immediately, and memory contents are not guaranteed.

Optional Feature:
- Macro: WSTORE_PARITY_EN.
- When defined:
  - Each word is stored with one extra even-parity bit computed over i_wgt_in.
  - On every word presented with o_weight_val=1, parity is rechecked.
  - A mismatch sets o_parity_err, which is sticky until reset or i_init_addr.
- When not defined: no extra storage; o_parity_err is tied to 0.

Test Plan:
- Write 0x0001..0x0010 (16 words); i_rst_addr with base 0; i_rd held high, i_weight_rdy=1 -> o_weight 0x0001..0x0010 on consecutive cycles, first valid 1 cycle after the first accept, o_wr_count=16.
- DEPTH=16: write 17 words -> o_full=1 after the 16th, the 17th is ignored, o_wr_count=16; i_init_addr with i_wgt_wr in the same cycle -> o_wr_count=0.
- LOOP_MODE=1, 4 words written (A,B,C,D), base=1; 7 reads -> B,C,D,B,C,D,B.
- i_weight_rdy toggled 1,0,0,1 under continuous i_rd -> o_rd_ready drops within 1 cycle, o_weight holds during the stall, full sequence with no loss or duplicates.
- NUM_BANKS=4, DEPTH=64: write 64 words (value = address); read addresses 15,16,31,32 -> outputs 15,16,31,32 (bank crossings correct).
- WSTORE_PARITY_EN: force one stored bit flip via backdoor; read that word -> o_parity_err=1 and stays set; i_init_addr -> 0.

Source files
------------

// File: rtl/ice40_weight_store_gen_if.sv
// rtl/ice40_weight_store_gen_if.sv - write/read port bundle for the weight store
interface ice40_weight_store_gen_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 14
);
    logic              i_init_addr;
    logic              i_wgt_wr;
    logic [DATA_W-1:0] i_wgt_in;
    logic              o_full;
    logic [AW:0]       o_wr_count;
    logic              i_rst_addr;
    logic [AW-1:0]     i_base_addr;
    logic              i_rd;
    logic              o_rd_ready;
    logic [DATA_W-1:0] o_weight;
    logic              o_weight_val;
    logic              i_weight_rdy;
    logic              o_parity_err;

    modport master (
        output i_init_addr, i_wgt_wr, i_wgt_in, i_rst_addr, i_base_addr, i_rd, i_weight_rdy,
        input  o_full, o_wr_count, o_rd_ready, o_weight, o_weight_val, o_parity_err
    );

    modport slave (
        input  i_init_addr, i_wgt_wr, i_wgt_in, i_rst_addr, i_base_addr, i_rd, i_weight_rdy,
        output o_full, o_wr_count, o_rd_ready, o_weight, o_weight_val, o_parity_err
    );
endinterface

// File: rtl/ice40_weight_store_gen.sv
// rtl/ice40_weight_store_gen.sv - banked weight store with skid-buffered sequential read port; optional WSTORE_PARITY_EN
module ice40_weight_store_gen #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 16384,
    parameter int NUM_BANKS = 1,
    parameter int LOOP_MODE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    ice40_weight_store_gen_if.slave bus
);
    localparam int AW         = $clog2(DEPTH);
    localparam int BBITS      = $clog2(NUM_BANKS);
    localparam int SELW       = (BBITS > 0) ? BBITS : 1;
    localparam int LAW        = AW - BBITS;
    localparam int LOW        = (LAW > 0) ? LAW : 1;
    localparam int BANK_DEPTH = DEPTH / NUM_BANKS;
`ifdef WSTORE_PARITY_EN
    localparam int MW = DATA_W + 1;
`else
    localparam int MW = DATA_W;
`endif

    // Upper address bits pick the bank; with one bank the shift leaves zero.
    function automatic logic [SELW-1:0] bank_of(input logic [AW-1:0] a);
        return SELW'(a >> LAW);
    endfunction

    function automatic logic [LOW-1:0] off_of(input logic [AW-1:0] a);
        return LOW'(a & AW'((1 << LAW) - 1));
    endfunction

    logic [AW-1:0]   waddr;
    logic [AW-1:0]   raddr;
    logic [AW-1:0]   base_q;
    logic [AW-1:0]   next_raddr;
    logic [AW:0]     wr_count;
    logic            wr_acc;
    logic            rd_acc;
    logic [MW-1:0]   wr_word;
    logic [MW-1:0]   bank_q [NUM_BANKS];
    logic            rd_pend;
    logic [SELW-1:0] rd_bank;
    logic [MW-1:0]   pend_word;
    logic [MW-1:0]   skid [2];
    logic [1:0]      occ;
    logic            head_val;
    logic [MW-1:0]   head_word;
    logic            pop;

    assign bus.o_full     = (wr_count == (AW+1)'(DEPTH));
    assign bus.o_wr_count = wr_count;
    assign wr_acc = !reset && bus.i_wgt_wr && !bus.o_full && !bus.i_init_addr;
    assign rd_acc = bus.i_rd && bus.o_rd_ready && !bus.i_rst_addr;

    // Each bank: one write port and a registered read (read-before-write on collision).
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [MW-1:0] mem [BANK_DEPTH];
        logic [MW-1:0] q;
        always_ff @(posedge clk) begin
            if (wr_acc && bank_of(waddr) == SELW'(b))
                mem[off_of(waddr)] <= wr_word;
            if (rd_acc && bank_of(raddr) == SELW'(b))
                q <= mem[off_of(raddr)];
        end
        assign bank_q[b] = q;
    end

    // Write pointer and count; init wins over a coincident write.
    always_ff @(posedge clk) begin
        if (reset || bus.i_init_addr) begin
            waddr    <= '0;
            wr_count <= '0;
        end else if (wr_acc) begin
            waddr    <= waddr + AW'(1);
            wr_count <= wr_count + (AW+1)'(1);
        end
    end

    // Next read address: linear wrap, or loop from last written word back to the base.
    always_comb begin
        next_raddr = raddr + AW'(1);
        if (LOOP_MODE != 0) begin
            if (wr_count == '0)
                next_raddr = raddr;
            else if (({1'b0, raddr} + (AW+1)'(1)) == wr_count)
                next_raddr = base_q;
        end
    end

    // Read pointer and latched base.
    always_ff @(posedge clk) begin
        if (reset) begin
            raddr  <= '0;
            base_q <= '0;
        end else if (bus.i_rst_addr) begin
            raddr  <= bus.i_base_addr;
            base_q <= bus.i_base_addr;
        end else if (rd_acc) begin
            raddr <= next_raddr;
        end
    end

    // Pick the bank that the in-flight read was issued to.
    always_comb begin
        pend_word = bank_q[0];
        for (int i = 1; i < NUM_BANKS; i++)
            if (rd_bank == SELW'(i))
                pend_word = bank_q[i];
    end

    // Oldest skid entry is presented first; an empty skid passes the fresh read straight out.
    assign head_val        = (occ != 2'd0) || rd_pend;
    assign head_word       = (occ != 2'd0) ? skid[0] : (rd_pend ? pend_word : '0);
    assign pop             = head_val && bus.i_weight_rdy;
    assign bus.o_weight     = head_word[DATA_W-1:0];
    assign bus.o_weight_val = head_val;
    assign bus.o_rd_ready   = !reset && ((occ + {1'b0, rd_pend}) < 2'd2);

    // In-flight tracking and 2-entry skid; flushed by reset or a read-pointer reload.
    always_ff @(posedge clk) begin
        if (reset || bus.i_rst_addr) begin
            occ     <= 2'd0;
            rd_pend <= 1'b0;
            rd_bank <= '0;
        end else begin
            rd_pend <= rd_acc;
            if (rd_acc)
                rd_bank <= bank_of(raddr);
            unique case ({rd_pend, pop})
                2'b01: begin
                    skid[0] <= skid[1];
                    occ     <= occ - 2'd1;
                end
                2'b10: begin
                    skid[occ[0]] <= pend_word;
                    occ          <= occ + 2'd1;
                end
                2'b11: begin
                    if (occ != 2'd0)
                        skid[0] <= pend_word;
                end
                default: ;
            endcase
        end
    end

`ifdef WSTORE_PARITY_EN
    logic par_err;
    assign wr_word          = {^bus.i_wgt_in, bus.i_wgt_in};
    assign bus.o_parity_err = par_err;

    // Sticky even-parity check on every presented word.
    always_ff @(posedge clk) begin
        if (reset || bus.i_init_addr)
            par_err <= 1'b0;
        else if (head_val && (^head_word))
            par_err <= 1'b1;
    end
`else
    assign wr_word          = bus.i_wgt_in;
    assign bus.o_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_ice40_weight_store_gen.sv
// tb/tb_ice40_weight_store_gen.sv - randomized self-checking bench for ice40_weight_store_gen
module tb_ice40_weight_store_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    ice40_weight_store_gen_if #(.DATA_W(16), .AW(4)) bus_a ();
    ice40_weight_store_gen_if #(.DATA_W(16), .AW(4)) bus_b ();
    ice40_weight_store_gen_if #(.DATA_W(8),  .AW(6)) bus_c ();

    ice40_weight_store_gen #(.DATA_W(16), .DEPTH(16), .NUM_BANKS(1), .LOOP_MODE(0))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    ice40_weight_store_gen #(.DATA_W(16), .DEPTH(16), .NUM_BANKS(1), .LOOP_MODE(1))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    ice40_weight_store_gen #(.DATA_W(8), .DEPTH(64), .NUM_BANKS(4), .LOOP_MODE(0))
        dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    logic [15:0] model_a [16];
    logic [15:0] got_a [$];
    logic [15:0] got_b [$];
    logic [7:0]  got_c [$];
    int first_acc, first_val, stall_bad, max_out, cyc_used;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1);
    end

    task automatic idle_all;
        bus_a.i_init_addr = 0; bus_a.i_wgt_wr = 0; bus_a.i_wgt_in = '0; bus_a.i_rst_addr = 0;
        bus_a.i_base_addr = '0; bus_a.i_rd = 0; bus_a.i_weight_rdy = 1;
        bus_b.i_init_addr = 0; bus_b.i_wgt_wr = 0; bus_b.i_wgt_in = '0; bus_b.i_rst_addr = 0;
        bus_b.i_base_addr = '0; bus_b.i_rd = 0; bus_b.i_weight_rdy = 1;
        bus_c.i_init_addr = 0; bus_c.i_wgt_wr = 0; bus_c.i_wgt_in = '0; bus_c.i_rst_addr = 0;
        bus_c.i_base_addr = '0; bus_c.i_rd = 0; bus_c.i_weight_rdy = 1;
    endtask

    task automatic pulse_init(input int which);
        @(negedge clk);
        if (which == 0) bus_a.i_init_addr = 1;
        if (which == 1) bus_b.i_init_addr = 1;
        if (which == 2) bus_c.i_init_addr = 1;
        @(negedge clk);
        bus_a.i_init_addr = 0; bus_b.i_init_addr = 0; bus_c.i_init_addr = 0;
    endtask

    task automatic pulse_rst(input int which, input int base);
        @(negedge clk);
        if (which == 0) begin bus_a.i_rst_addr = 1; bus_a.i_base_addr = 4'(base); end
        if (which == 1) begin bus_b.i_rst_addr = 1; bus_b.i_base_addr = 4'(base); end
        if (which == 2) begin bus_c.i_rst_addr = 1; bus_c.i_base_addr = 6'(base); end
        @(negedge clk);
        bus_a.i_rst_addr = 0; bus_b.i_rst_addr = 0; bus_c.i_rst_addr = 0;
    endtask

    task automatic write_a(input logic [15:0] d);
        @(negedge clk);
        bus_a.i_wgt_wr = 1; bus_a.i_wgt_in = d;
    endtask

    task automatic end_wr_a;
        @(negedge clk);
        bus_a.i_wgt_wr = 0;
    endtask

    // Drives i_rd until n accepts, consumer ready per mode (0 always, 1 pattern 1,0,0,1, 2 random).
    task automatic run_a(input int n, input int mode, input int max_cyc);
        int acc = 0;
        int cyc = 0;
        int outst = 0;
        logic stalled = 0;
        logic [15:0] held = '0;
        got_a.delete();
        first_acc = -1; first_val = -1; stall_bad = 0; max_out = 0;
        while ((acc < n || got_a.size() < n) && cyc < max_cyc) begin
            @(negedge clk);
            bus_a.i_rd = (acc < n);
            if (mode == 0) bus_a.i_weight_rdy = 1;
            else if (mode == 1) bus_a.i_weight_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            else bus_a.i_weight_rdy = 1'($urandom_range(0, 1));
            #1;
            if (stalled && (!bus_a.o_weight_val || bus_a.o_weight !== held)) stall_bad++;
            if (bus_a.o_weight_val && first_val < 0) first_val = cyc;
            if (bus_a.i_rd && bus_a.o_rd_ready) begin
                acc++; outst++;
                if (first_acc < 0) first_acc = cyc;
            end
            if (bus_a.o_weight_val && bus_a.i_weight_rdy) begin
                got_a.push_back(bus_a.o_weight);
                outst--;
            end
            if (outst > max_out) max_out = outst;
            stalled = bus_a.o_weight_val && !bus_a.i_weight_rdy;
            held = bus_a.o_weight;
            cyc++;
        end
        cyc_used = cyc;
        @(negedge clk);
        bus_a.i_rd = 0; bus_a.i_weight_rdy = 1;
    endtask

    task automatic read_b(input int n);
        int acc = 0;
        int cyc = 0;
        got_b.delete();
        bus_b.i_weight_rdy = 1;
        while ((acc < n || got_b.size() < n) && cyc < 100) begin
            @(negedge clk);
            bus_b.i_rd = (acc < n);
            #1;
            if (bus_b.i_rd && bus_b.o_rd_ready) acc++;
            if (bus_b.o_weight_val) got_b.push_back(bus_b.o_weight);
            cyc++;
        end
        @(negedge clk);
        bus_b.i_rd = 0;
    endtask

    task automatic read_c(input int n);
        int acc = 0;
        int cyc = 0;
        got_c.delete();
        bus_c.i_weight_rdy = 1;
        while ((acc < n || got_c.size() < n) && cyc < 100) begin
            @(negedge clk);
            bus_c.i_rd = (acc < n);
            #1;
            if (bus_c.i_rd && bus_c.o_rd_ready) acc++;
            if (bus_c.o_weight_val) got_c.push_back(bus_c.o_weight);
            cyc++;
        end
        @(negedge clk);
        bus_c.i_rd = 0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle_all();
        repeat (3) @(negedge clk);
        #1;
        total_cnt++;
        if ({bus_a.o_rd_ready, bus_b.o_rd_ready, bus_c.o_rd_ready} !== 3'b000)
            $display("FAIL reset_ready_low: got %b%b%b expected 000", bus_a.o_rd_ready, bus_b.o_rd_ready, bus_c.o_rd_ready);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({bus_a.o_rd_ready, bus_b.o_rd_ready, bus_c.o_rd_ready} !== 3'b111)
            $display("FAIL reset_ready_high: got %b%b%b expected 111", bus_a.o_rd_ready, bus_b.o_rd_ready, bus_c.o_rd_ready);
        else pass_cnt++;
        total_cnt++;
        if ({bus_a.o_weight_val, bus_b.o_weight_val, bus_c.o_weight_val, bus_a.o_full, bus_b.o_full,
             bus_c.o_full, bus_a.o_parity_err, bus_b.o_parity_err, bus_c.o_parity_err} !== 9'b0)
            $display("FAIL reset_flags: val/full/perr not all 0 expected 0");
        else pass_cnt++;
        total_cnt++;
        if (bus_a.o_wr_count !== 5'd0 || bus_b.o_wr_count !== 5'd0 || bus_c.o_wr_count !== 7'd0)
            $display("FAIL reset_count: got %0d/%0d/%0d expected 0", bus_a.o_wr_count, bus_b.o_wr_count, bus_c.o_wr_count);
        else pass_cnt++;
        total_cnt++;
        if (bus_a.o_weight !== 16'h0)
            $display("FAIL reset_weight: got %h expected 0000", bus_a.o_weight);
        else pass_cnt++;
    endtask

    task automatic test_seq_read;
        pulse_init(0);
        for (int i = 0; i < 16; i++) begin
            model_a[i] = 16'(i + 1);
            write_a(model_a[i]);
        end
        end_wr_a();
        #1;
        total_cnt++;
        if (bus_a.o_wr_count !== 5'd16 || bus_a.o_full !== 1'b1)
            $display("FAIL seq_count: got count %0d full %b expected 16 1", bus_a.o_wr_count, bus_a.o_full);
        else pass_cnt++;
        pulse_rst(0, 0);
        run_a(16, 0, 60);
        total_cnt++;
        if (got_a.size() != 16) $display("FAIL seq_size: got %0d words expected 16", got_a.size());
        else pass_cnt++;
        for (int k = 0; k < 16; k++) begin
            logic [15:0] g;
            g = (k < got_a.size()) ? got_a[k] : 16'hxxxx;
            total_cnt++;
            if (g !== 16'(k + 1)) $display("FAIL seq_data[%0d]: got %h expected %h", k, g, 16'(k + 1));
            else pass_cnt++;
        end
        total_cnt++;
        if (first_val != first_acc + 1)
            $display("FAIL seq_latency: first valid cycle %0d expected %0d", first_val, first_acc + 1);
        else pass_cnt++;
        total_cnt++;
        if (cyc_used != 17) $display("FAIL seq_throughput: got %0d cycles expected 17", cyc_used);
        else pass_cnt++;
    endtask

    task automatic test_full_and_init;
        write_a(16'hDEAD);
        end_wr_a();
        #1;
        total_cnt++;
        if (bus_a.o_wr_count !== 5'd16 || bus_a.o_full !== 1'b1)
            $display("FAIL full_drop_count: got %0d full %b expected 16 1", bus_a.o_wr_count, bus_a.o_full);
        else pass_cnt++;
        pulse_rst(0, 0);
        run_a(1, 0, 20);
        total_cnt++;
        if (got_a.size() != 1 || got_a[0] !== model_a[0])
            $display("FAIL full_drop_data: got %h expected %h", (got_a.size() > 0) ? got_a[0] : 16'hxxxx, model_a[0]);
        else pass_cnt++;
        @(negedge clk);
        bus_a.i_init_addr = 1; bus_a.i_wgt_wr = 1; bus_a.i_wgt_in = 16'hBEEF;
        @(negedge clk);
        bus_a.i_init_addr = 0; bus_a.i_wgt_wr = 0;
        #1;
        total_cnt++;
        if (bus_a.o_wr_count !== 5'd0 || bus_a.o_full !== 1'b0)
            $display("FAIL init_with_write: got count %0d full %b expected 0 0", bus_a.o_wr_count, bus_a.o_full);
        else pass_cnt++;
        pulse_rst(0, 0);
        run_a(1, 0, 20);
        total_cnt++;
        if (got_a.size() != 1 || got_a[0] !== model_a[0])
            $display("FAIL init_write_dropped: got %h expected %h", (got_a.size() > 0) ? got_a[0] : 16'hxxxx, model_a[0]);
        else pass_cnt++;
    endtask

    task automatic test_loop_mode;
        logic [15:0] w [4];
        int bases [2] = '{1, 2};
        int lens [2] = '{7, 5};
        pulse_init(1);
        for (int i = 0; i < 4; i++) begin
            w[i] = 16'($urandom);
            @(negedge clk);
            bus_b.i_wgt_wr = 1; bus_b.i_wgt_in = w[i];
        end
        @(negedge clk);
        bus_b.i_wgt_wr = 0;
        #1;
        total_cnt++;
        if (bus_b.o_wr_count !== 5'd4) $display("FAIL loop_count: got %0d expected 4", bus_b.o_wr_count);
        else pass_cnt++;
        for (int t = 0; t < 2; t++) begin
            pulse_rst(1, bases[t]);
            read_b(lens[t]);
            total_cnt++;
            if (got_b.size() != lens[t]) $display("FAIL loop_size: got %0d expected %0d", got_b.size(), lens[t]);
            else pass_cnt++;
            for (int k = 0; k < lens[t]; k++) begin
                logic [15:0] e;
                logic [15:0] g;
                e = w[bases[t] + (k % (4 - bases[t]))];
                g = (k < got_b.size()) ? got_b[k] : 16'hxxxx;
                total_cnt++;
                if (g !== e) $display("FAIL loop_data[b%0d,%0d]: got %h expected %h", bases[t], k, g, e);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_banks;
        int starts [4] = '{15, 31, 47, 63};
        pulse_init(2);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bus_c.i_wgt_wr = 1; bus_c.i_wgt_in = 8'(i);
        end
        @(negedge clk);
        bus_c.i_wgt_wr = 0;
        #1;
        total_cnt++;
        if (bus_c.o_wr_count !== 7'd64 || bus_c.o_full !== 1'b1)
            $display("FAIL bank_count: got %0d full %b expected 64 1", bus_c.o_wr_count, bus_c.o_full);
        else pass_cnt++;
        for (int t = 0; t < 4; t++) begin
            logic [7:0] g0;
            logic [7:0] g1;
            pulse_rst(2, starts[t]);
            read_c(2);
            g0 = (got_c.size() > 0) ? got_c[0] : 8'hxx;
            g1 = (got_c.size() > 1) ? got_c[1] : 8'hxx;
            total_cnt++;
            if (g0 !== 8'(starts[t]) || g1 !== 8'((starts[t] + 1) % 64))
                $display("FAIL bank_cross[%0d]: got %0d,%0d expected %0d,%0d", starts[t], g0, g1,
                         starts[t], (starts[t] + 1) % 64);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_pressure;
        int base;
        int idx;
        int bad;
        pulse_init(0);
        for (int i = 0; i < 16; i++) begin
            model_a[i] = 16'($urandom);
            write_a(model_a[i]);
        end
        end_wr_a();
        base = $urandom_range(0, 15);
        pulse_rst(0, base);
        idx = base;
        for (int pass = 0; pass < 2; pass++) begin
            int n;
            n = (pass == 0) ? 20 : 30;
            run_a(n, pass + 1, 400);
            total_cnt++;
            if (got_a.size() != n) $display("FAIL bp_size[%0d]: got %0d expected %0d", pass, got_a.size(), n);
            else pass_cnt++;
            bad = 0;
            for (int k = 0; k < got_a.size(); k++)
                if (got_a[k] !== model_a[(idx + k) % 16]) bad++;
            total_cnt++;
            if (bad != 0) $display("FAIL bp_order[%0d]: got %0d wrong words expected 0", pass, bad);
            else pass_cnt++;
            total_cnt++;
            if (stall_bad != 0) $display("FAIL bp_hold[%0d]: got %0d unstable stalls expected 0", pass, stall_bad);
            else pass_cnt++;
            total_cnt++;
            if (max_out > 2) $display("FAIL bp_ready[%0d]: got %0d outstanding expected <=2", pass, max_out);
            else pass_cnt++;
            idx = (idx + n) % 16;
        end
    endtask

    task automatic test_rst_flush;
        pulse_rst(0, 3);
        @(negedge clk);
        bus_a.i_rd = 1; bus_a.i_weight_rdy = 0;
        repeat (4) @(negedge clk);
        #1;
        total_cnt++;
        if (bus_a.o_weight_val !== 1'b1 || bus_a.o_weight !== model_a[3] || bus_a.o_rd_ready !== 1'b0)
            $display("FAIL stall_full: got val %b data %h ready %b expected 1 %h 0", bus_a.o_weight_val,
                     bus_a.o_weight, bus_a.o_rd_ready, model_a[3]);
        else pass_cnt++;
        bus_a.i_rst_addr = 1; bus_a.i_base_addr = 4'd9;
        @(negedge clk);
        bus_a.i_rst_addr = 0; bus_a.i_rd = 0; bus_a.i_weight_rdy = 1;
        #1;
        total_cnt++;
        if (bus_a.o_weight_val !== 1'b0) $display("FAIL flush_val: got %b expected 0", bus_a.o_weight_val);
        else pass_cnt++;
        run_a(1, 0, 20);
        total_cnt++;
        if (got_a.size() != 1 || got_a[0] !== model_a[9])
            $display("FAIL flush_base: got %h expected %h", (got_a.size() > 0) ? got_a[0] : 16'hxxxx, model_a[9]);
        else pass_cnt++;
    endtask

    task automatic test_parity;
        #1;
        total_cnt++;
        if ({bus_a.o_parity_err, bus_b.o_parity_err, bus_c.o_parity_err} !== 3'b000)
            $display("FAIL parity_clean: got %b%b%b expected 000", bus_a.o_parity_err, bus_b.o_parity_err, bus_c.o_parity_err);
        else pass_cnt++;
`ifdef WSTORE_PARITY_EN
        dut_a.g_bank[0].mem[5] = dut_a.g_bank[0].mem[5] ^ 17'h00001;
        pulse_rst(0, 5);
        run_a(1, 0, 20);
        #1;
        total_cnt++;
        if (got_a.size() != 1 || got_a[0] !== (model_a[5] ^ 16'h0001))
            $display("FAIL parity_word: got %h expected %h", (got_a.size() > 0) ? got_a[0] : 16'hxxxx, model_a[5] ^ 16'h0001);
        else pass_cnt++;
        total_cnt++;
        if (bus_a.o_parity_err !== 1'b1) $display("FAIL parity_set: got %b expected 1", bus_a.o_parity_err);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        #1;
        total_cnt++;
        if (bus_a.o_parity_err !== 1'b1) $display("FAIL parity_sticky: got %b expected 1", bus_a.o_parity_err);
        else pass_cnt++;
        pulse_init(0);
        #1;
        total_cnt++;
        if (bus_a.o_parity_err !== 1'b0) $display("FAIL parity_clear: got %b expected 0", bus_a.o_parity_err);
        else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset();
        test_seq_read();
        test_full_and_init();
        test_loop_mode();
        test_banks();
        test_back_pressure();
        test_rst_flush();
        test_parity();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
